pll_dyn_ctrl: RTL and testbench

Dynamic reconfiguration controller that drives the dynamic-ratio, reset and phase-step inputs of the team's GTP_PLL_E3 wrapper and qualifies its LOCK output. It accepts divider sets over a valid/ready handshake, resets the PLL, applies new ratios, waits for a filtered lock with timeout, and optionally issues fine phase steps. It sits in the clock-management layer between the system control registers and the PLL instance.

---
 rtl/pll_dyn_ctrl_if.sv | 33 +++
 rtl/pll_dyn_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_dyn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_dyn_ctrl_if
// Purpose  : Handshake bundle carrying divider-set and phase-step requests
//            into pll_dyn_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface pll_dyn_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] cfg_idiv;
    logic [9:0] cfg_fdiv;
    logic [9:0] cfg_odiv0;
    logic [9:0] cfg_duty0;
    logic       phase_req;
    logic       phase_ready;
    logic [2:0] phase_sel_in;
    logic       phase_dir_in;
    logic [7:0] phase_steps;

    modport master (
        output cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_duty0,
        output phase_req, phase_sel_in, phase_dir_in, phase_steps,
        input  cfg_ready, phase_ready
    );

    modport slave (
        input  cfg_valid, cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_duty0,
        input  phase_req, phase_sel_in, phase_dir_in, phase_steps,
        output cfg_ready, phase_ready
    );
endinterface
`default_nettype wire

// File: rtl/pll_dyn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_dyn_ctrl
// Purpose  : Dynamic ratio / reset / phase-step controller for GTP_PLL_E3 with
//            filtered lock and timeout. Define PLL_DYN_PHASE_EN for phase steps.
// Revision : 1.0  initial release
// ============================================================================
module pll_dyn_ctrl #(
    parameter int DEF_IDIV     = 2,
    parameter int DEF_FDIV     = 30,
    parameter int DEF_ODIV0    = 3,
    parameter int DEF_DUTY0    = 3,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STEP_GAP     = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pll_dyn_ctrl_if.slave   ctl,
    input  wire logic       pll_lock,
    output logic            pll_rst,
    output logic [9:0]      dyn_idiv,
    output logic [9:0]      dyn_fdiv,
    output logic [9:0]      dyn_odiv0,
    output logic [9:0]      dyn_duty0,
    output logic [2:0]      phase_sel,
    output logic            phase_dir,
    output logic            phase_step_n,
    output logic            locked,
    output logic            busy,
    output logic            err_timeout,
    output logic            err_cfg
);

    localparam logic [15:0] c_hold_last = 16'(RST_HOLD - 1);
    localparam logic [15:0] c_filt_last = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] c_tmo_last  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [9:0]  c_def_idiv  = 10'(DEF_IDIV);
    localparam logic [9:0]  c_def_fdiv  = 10'(DEF_FDIV);
    localparam logic [9:0]  c_def_odiv0 = 10'(DEF_ODIV0);
    localparam logic [9:0]  c_def_duty0 = 10'(DEF_DUTY0);

    typedef enum logic [2:0] {
        S_RST_ASSERT = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_LOCKED     = 3'd2,
        S_ERROR      = 3'd3
`ifdef PLL_DYN_PHASE_EN
        ,
        S_STEP       = 3'd4,
        S_GAP        = 3'd5
`endif
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_lock_meta, r_lock_sync;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_filt, w_filt_nxt;
    logic [9:0]  r_idiv, r_fdiv, r_odiv0, r_duty0;
    logic [9:0]  w_idiv_nxt, w_fdiv_nxt, w_odiv0_nxt, w_duty0_nxt;
    logic        r_err_timeout, w_err_timeout_nxt;
    logic        r_err_cfg, w_err_cfg_nxt;
    logic        r_pll_rst;
    logic        w_cfg_ready, w_cfg_fire, w_cfg_bad;

`ifdef PLL_DYN_PHASE_EN
    localparam logic [15:0] c_gap_last = 16'(STEP_GAP - 1);
    logic [7:0]  r_remain, w_remain_nxt;
    logic [2:0]  r_phase_sel, w_phase_sel_nxt;
    logic        r_phase_dir, w_phase_dir_nxt;
    logic        r_step_n;
    logic        w_phase_fire;

    assign w_phase_fire    = (r_state == S_LOCKED) && ctl.phase_req &&
                             !ctl.cfg_valid && r_lock_sync;
    assign ctl.phase_ready = w_phase_fire;
    assign phase_sel       = r_phase_sel;
    assign phase_dir       = r_phase_dir;
    assign phase_step_n    = r_step_n;
    assign locked          = (r_state == S_LOCKED) || (r_state == S_STEP) ||
                             (r_state == S_GAP);
`else
    assign ctl.phase_ready = 1'b0;
    assign phase_sel       = 3'd0;
    assign phase_dir       = 1'b0;
    assign phase_step_n    = 1'b1;
    assign locked          = (r_state == S_LOCKED);
`endif

    assign w_cfg_ready   = (r_state == S_LOCKED) || (r_state == S_ERROR);
    assign ctl.cfg_ready = w_cfg_ready;
    assign w_cfg_fire    = ctl.cfg_valid && w_cfg_ready;
    // Duty may legitimately be zero; the three dividers may not.
    assign w_cfg_bad     = (ctl.cfg_idiv == 10'd0) || (ctl.cfg_fdiv == 10'd0) ||
                           (ctl.cfg_odiv0 == 10'd0);

    assign busy        = !w_cfg_ready;
    assign pll_rst     = r_pll_rst;
    assign dyn_idiv    = r_idiv;
    assign dyn_fdiv    = r_fdiv;
    assign dyn_odiv0   = r_odiv0;
    assign dyn_duty0   = r_duty0;
    assign err_timeout = r_err_timeout;
    assign err_cfg     = r_err_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RST_ASSERT;
            r_lock_meta   <= 1'b0;
            r_lock_sync   <= 1'b0;
            r_cnt         <= 16'd0;
            r_filt        <= 16'd0;
            r_idiv        <= c_def_idiv;
            r_fdiv        <= c_def_fdiv;
            r_odiv0       <= c_def_odiv0;
            r_duty0       <= c_def_duty0;
            r_err_timeout <= 1'b0;
            r_err_cfg     <= 1'b0;
            r_pll_rst     <= 1'b1;
`ifdef PLL_DYN_PHASE_EN
            r_remain      <= 8'd0;
            r_phase_sel   <= 3'd0;
            r_phase_dir   <= 1'b0;
            r_step_n      <= 1'b1;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_lock_meta   <= pll_lock;
            r_lock_sync   <= r_lock_meta;
            r_cnt         <= w_cnt_nxt;
            r_filt        <= w_filt_nxt;
            r_idiv        <= w_idiv_nxt;
            r_fdiv        <= w_fdiv_nxt;
            r_odiv0       <= w_odiv0_nxt;
            r_duty0       <= w_duty0_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_err_cfg     <= w_err_cfg_nxt;
            // PLL-facing strobes are registered from next state to stay glitch-free.
            r_pll_rst     <= (w_state_nxt == S_RST_ASSERT);
`ifdef PLL_DYN_PHASE_EN
            r_remain      <= w_remain_nxt;
            r_phase_sel   <= w_phase_sel_nxt;
            r_phase_dir   <= w_phase_dir_nxt;
            r_step_n      <= (w_state_nxt != S_STEP);
`endif
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_filt_nxt        = r_filt;
        w_idiv_nxt        = r_idiv;
        w_fdiv_nxt        = r_fdiv;
        w_odiv0_nxt       = r_odiv0;
        w_duty0_nxt       = r_duty0;
        w_err_timeout_nxt = r_err_timeout;
        w_err_cfg_nxt     = 1'b0;
`ifdef PLL_DYN_PHASE_EN
        w_remain_nxt      = r_remain;
        w_phase_sel_nxt   = r_phase_sel;
        w_phase_dir_nxt   = r_phase_dir;
`endif
        case (r_state)
            S_RST_ASSERT: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = 16'd0;
                    w_filt_nxt  = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (r_lock_sync && (r_filt == c_filt_last)) begin
                    w_state_nxt = S_LOCKED;
                end else if (r_cnt == c_tmo_last) begin
                    w_state_nxt       = S_ERROR;
                    w_err_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + 16'd1;
                    w_filt_nxt = r_lock_sync ? (r_filt + 16'd1) : 16'd0;
                end
            end
            S_LOCKED, S_ERROR: begin
                if (w_cfg_fire && !w_cfg_bad) begin
                    w_idiv_nxt        = ctl.cfg_idiv;
                    w_fdiv_nxt        = ctl.cfg_fdiv;
                    w_odiv0_nxt       = ctl.cfg_odiv0;
                    w_duty0_nxt       = ctl.cfg_duty0;
                    w_err_timeout_nxt = 1'b0;
                    w_state_nxt       = S_RST_ASSERT;
                    w_cnt_nxt         = 16'd0;
                end else begin
                    w_err_cfg_nxt = w_cfg_fire;
                    if (r_state == S_LOCKED) begin
                        if (!r_lock_sync) begin
                            w_state_nxt = S_WAIT_LOCK;
                            w_cnt_nxt   = 16'd0;
                            w_filt_nxt  = 16'd0;
                        end
`ifdef PLL_DYN_PHASE_EN
                        else if (w_phase_fire) begin
                            w_phase_sel_nxt = ctl.phase_sel_in;
                            w_phase_dir_nxt = ctl.phase_dir_in;
                            w_remain_nxt    = ctl.phase_steps;
                            // One setup GAP cycle lets sel/dir settle before the first pulse.
                            if (ctl.phase_steps != 8'd0) begin
                                w_state_nxt = S_GAP;
                                w_cnt_nxt   = c_gap_last;
                            end
                        end
`endif
                    end
                end
            end
`ifdef PLL_DYN_PHASE_EN
            S_STEP: begin
                w_remain_nxt = r_remain - 8'd1;
                if (!r_lock_sync) begin
                    w_state_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt    = 16'd0;
                    w_filt_nxt   = 16'd0;
                    w_remain_nxt = 8'd0;
                end else begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = 16'd0;
                end
            end
            S_GAP: begin
                if (!r_lock_sync) begin
                    w_state_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt    = 16'd0;
                    w_filt_nxt   = 16'd0;
                    w_remain_nxt = 8'd0;
                end else if (r_cnt == c_gap_last) begin
                    w_state_nxt = (r_remain != 8'd0) ? S_STEP : S_LOCKED;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_RST_ASSERT;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_dyn_ctrl
// Purpose  : Directed checks of pll_dyn_ctrl: reset, lock filter, cfg table,
//            timeout, lock loss and (with PLL_DYN_PHASE_EN) phase stepping.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_dyn_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst, phase_dir, phase_step_n, locked, busy, err_timeout, err_cfg;
    logic [9:0] dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0;
    logic [2:0] phase_sel;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    logic [9:0] e_idiv = 10'd2, e_fdiv = 10'd30, e_odiv0 = 10'd3, e_duty0 = 10'd3;

    typedef struct {
        logic [9:0] idiv;
        logic [9:0] fdiv;
        logic [9:0] odiv0;
        logic [9:0] duty0;
        logic       bad;
    } cfg_vec_t;

    cfg_vec_t vecs [6];

    pll_dyn_ctrl_if bus ();

    pll_dyn_ctrl #(.LOCK_TIMEOUT(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl          (bus),
        .pll_lock     (pll_lock),
        .pll_rst      (pll_rst),
        .dyn_idiv     (dyn_idiv),
        .dyn_fdiv     (dyn_fdiv),
        .dyn_odiv0    (dyn_odiv0),
        .dyn_duty0    (dyn_duty0),
        .phase_sel    (phase_sel),
        .phase_dir    (phase_dir),
        .phase_step_n (phase_step_n),
        .locked       (locked),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_cfg      (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_dyn(input string name);
        chk({name, "_idiv"},  32'(dyn_idiv),  32'(e_idiv));
        chk({name, "_fdiv"},  32'(dyn_fdiv),  32'(e_fdiv));
        chk({name, "_odiv0"}, 32'(dyn_odiv0), 32'(e_odiv0));
        chk({name, "_duty0"}, 32'(dyn_duty0), 32'(e_duty0));
    endtask

    task automatic drive_cfg(input cfg_vec_t v);
        bus.cfg_valid = 1'b1;
        bus.cfg_idiv  = v.idiv;
        bus.cfg_fdiv  = v.fdiv;
        bus.cfg_odiv0 = v.odiv0;
        bus.cfg_duty0 = v.duty0;
    endtask

    // Entered in cycle N+1 after an accepted cfg; the PLL drops lock during its
    // reset and reasserts it in cycle N+20, so locked is due in N+30.
    task automatic wait_relock();
        pll_lock = 1'b0;
        for (int j = 2; j <= 30; j++) begin
            tick();
            if (j == 20) pll_lock = 1'b1;
            if (j == 16) chk("rst_hold_last", 32'(pll_rst), 32'd1);
            if (j == 17) chk("rst_released", 32'(pll_rst), 32'd0);
            if (j == 29) chk("relock_early", 32'(locked), 32'd0);
            if (j == 30) begin
                chk("relock", 32'(locked), 32'd1);
                chk("relock_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic apply_cfg(input cfg_vec_t v);
        chk("cfg_ready", 32'(bus.cfg_ready), 32'd1);
        drive_cfg(v);
        tick();
        bus.cfg_valid = 1'b0;
        if (!v.bad) begin
            e_idiv  = v.idiv;
            e_fdiv  = v.fdiv;
            e_odiv0 = v.odiv0;
            e_duty0 = v.duty0;
        end
        chk("err_cfg", 32'(err_cfg), 32'(v.bad));
        chk("accept_pll_rst", 32'(pll_rst), 32'(!v.bad));
        chk("accept_locked", 32'(locked), 32'(v.bad));
        chk("accept_busy", 32'(busy), 32'(!v.bad));
        chk_dyn("cfg_dyn");
        if (v.bad) begin
            tick();
            chk("err_cfg_pulse_end", 32'(err_cfg), 32'd0);
            chk("bad_stays_locked", 32'(locked), 32'd1);
        end else begin
            wait_relock();
        end
    endtask

    initial begin
        vecs[0] = '{idiv: 10'd1,    fdiv: 10'd20,   odiv0: 10'd4,    duty0: 10'd4,    bad: 1'b0};
        vecs[1] = '{idiv: 10'd5,    fdiv: 10'd0,    odiv0: 10'd4,    duty0: 10'd4,    bad: 1'b1};
        vecs[2] = '{idiv: 10'd0,    fdiv: 10'd10,   odiv0: 10'd2,    duty0: 10'd2,    bad: 1'b1};
        vecs[3] = '{idiv: 10'd3,    fdiv: 10'd40,   odiv0: 10'd0,    duty0: 10'd1,    bad: 1'b1};
        vecs[4] = '{idiv: 10'd7,    fdiv: 10'd50,   odiv0: 10'd6,    duty0: 10'd0,    bad: 1'b0};
        vecs[5] = '{idiv: 10'd1023, fdiv: 10'd1023, odiv0: 10'd1023, duty0: 10'd1023, bad: 1'b0};

        bus.cfg_valid    = 1'b0;
        bus.cfg_idiv     = '0;
        bus.cfg_fdiv     = '0;
        bus.cfg_odiv0    = '0;
        bus.cfg_duty0    = '0;
        bus.phase_req    = 1'b0;
        bus.phase_sel_in = '0;
        bus.phase_dir_in = 1'b0;
        bus.phase_steps  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_cfg", 32'(err_cfg), 32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst_phase_ready", 32'(bus.phase_ready), 32'd0);
        chk("rst_step_n", 32'(phase_step_n), 32'd1);
        chk("rst_phase_sel", 32'(phase_sel), 32'd0);
        chk_dyn("rst_dyn");

        // Bring-up: cycle 1 is the first cycle with rst_n high
        rst_n = 1'b1;
        cyc = 1;
        for (int k = 1; k <= 42; k++) begin
            if (k == 30) pll_lock = 1'b1;
            chk("bringup_pll_rst", 32'(pll_rst), 32'(k <= 16));
            chk("bringup_locked", 32'(locked), 32'(k >= 40));
            if (k == 39 || k == 40) chk("bringup_busy", 32'(busy), 32'(k < 40));
            tick();
        end

        // Lock loss from LOCKED: locked drops 3 cycles later, no PLL reset
        pll_lock = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (j == 5) pll_lock = 1'b1;
            if (j == 2) chk("loss_locked_still", 32'(locked), 32'd1);
            if (j == 3) begin
                chk("loss_locked", 32'(locked), 32'd0);
                chk("loss_no_rst", 32'(pll_rst), 32'd0);
                chk("loss_busy", 32'(busy), 32'd1);
            end
            if (j == 14) chk("loss_relock_early", 32'(locked), 32'd0);
            if (j == 15) chk("loss_relock", 32'(locked), 32'd1);
        end

        // Cfg vector table
        for (int i = 0; i < 6; i++) apply_cfg(vecs[i]);

        // Lock timeout: accept cfg with PLL never locking
        drive_cfg('{idiv: 10'd4, fdiv: 10'd32, odiv0: 10'd5, duty0: 10'd2, bad: 1'b0});
        tick();
        bus.cfg_valid = 1'b0;
        e_idiv = 10'd4; e_fdiv = 10'd32; e_odiv0 = 10'd5; e_duty0 = 10'd2;
        chk_dyn("tmo_dyn");
        pll_lock = 1'b0;
        for (int j = 2; j <= 117; j++) begin
            tick();
            if (j == 116) chk("tmo_not_yet", 32'(err_timeout), 32'd0);
            if (j == 117) begin
                chk("tmo_err", 32'(err_timeout), 32'd1);
                chk("tmo_cfg_ready", 32'(bus.cfg_ready), 32'd1);
                chk("tmo_locked", 32'(locked), 32'd0);
            end
        end
        drive_cfg('{idiv: 10'd0, fdiv: 10'd9, odiv0: 10'd9, duty0: 10'd9, bad: 1'b1});
        tick();
        bus.cfg_valid = 1'b0;
        chk("err_state_bad_cfg", 32'(err_cfg), 32'd1);
        chk("err_state_sticky", 32'(err_timeout), 32'd1);
        chk("err_state_no_rst", 32'(pll_rst), 32'd0);
        drive_cfg('{idiv: 10'd2, fdiv: 10'd30, odiv0: 10'd3, duty0: 10'd3, bad: 1'b0});
        tick();
        bus.cfg_valid = 1'b0;
        e_idiv = 10'd2; e_fdiv = 10'd30; e_odiv0 = 10'd3; e_duty0 = 10'd3;
        chk("tmo_cleared", 32'(err_timeout), 32'd0);
        chk("tmo_recfg_rst", 32'(pll_rst), 32'd1);
        chk_dyn("tmo_recfg_dyn");
        wait_relock();

`ifdef PLL_DYN_PHASE_EN
        // Three steps, sel=2, advance: pulses at M+2, M+7, M+12, LOCKED at M+17
        bus.phase_req = 1'b1; bus.phase_sel_in = 3'd2; bus.phase_dir_in = 1'b1;
        bus.phase_steps = 8'd3;
        chk("ph_ready", 32'(bus.phase_ready), 32'd1);
        tick();
        bus.phase_req = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            chk("ph_step_n", 32'(phase_step_n), 32'(!(j == 2 || j == 7 || j == 12)));
            if (j == 1 || j == 16) begin
                chk("ph_sel", 32'(phase_sel), 32'd2);
                chk("ph_dir", 32'(phase_dir), 32'd1);
            end
            if (j == 12) chk("ph_busy", 32'(busy), 32'd1);
            if (j == 17) chk("ph_done_busy", 32'(busy), 32'd0);
            if (j != 17) tick();
        end

        // Lock glitch in cycle M+7 (step 2): abort, locked low at M+10, relock M+18
        bus.phase_req = 1'b1; bus.phase_sel_in = 3'd5; bus.phase_dir_in = 1'b0;
        tick();
        bus.phase_req = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            if (j == 7) pll_lock = 1'b0;
            if (j == 8) pll_lock = 1'b1;
            chk("ab_step_n", 32'(phase_step_n), 32'(!(j == 2 || j == 7)));
            if (j == 9) chk("ab_locked_still", 32'(locked), 32'd1);
            if (j == 10) begin
                chk("ab_locked", 32'(locked), 32'd0);
                chk("ab_no_rst", 32'(pll_rst), 32'd0);
            end
            if (j == 17) chk("ab_relock_early", 32'(locked), 32'd0);
            if (j == 18) chk("ab_relock", 32'(locked), 32'd1);
            if (j != 18) tick();
        end

        // Zero steps: accepted, stays LOCKED
        bus.phase_req = 1'b1; bus.phase_steps = 8'd0;
        chk("z_ready", 32'(bus.phase_ready), 32'd1);
        tick();
        bus.phase_req = 1'b0;
        chk("z_busy", 32'(busy), 32'd0);
        tick();
        chk("z_step_n", 32'(phase_step_n), 32'd1);

        // cfg wins over a simultaneous phase request
        bus.phase_req = 1'b1; bus.phase_steps = 8'd2;
        drive_cfg('{idiv: 10'd3, fdiv: 10'd33, odiv0: 10'd3, duty0: 10'd3, bad: 1'b0});
        chk("both_phase_ready", 32'(bus.phase_ready), 32'd0);
        tick();
        bus.cfg_valid = 1'b0; bus.phase_req = 1'b0;
        chk("both_cfg_rst", 32'(pll_rst), 32'd1);
        chk("both_step_n", 32'(phase_step_n), 32'd1);
        wait_relock();
`else
        // Phase path absent: requests are ignored
        bus.phase_req = 1'b1; bus.phase_sel_in = 3'd2; bus.phase_dir_in = 1'b1;
        bus.phase_steps = 8'd3;
        for (int j = 0; j < 12; j++) begin
            if (j == 0 || j == 11) begin
                chk("nph_ready", 32'(bus.phase_ready), 32'd0);
                chk("nph_busy", 32'(busy), 32'd0);
                chk("nph_sel", 32'(phase_sel), 32'd0);
            end
            chk("nph_step_n", 32'(phase_step_n), 32'd1);
            tick();
        end
        bus.phase_req = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
